// File: rtl/alu_sel_debounce.sv
// Conditions the raw active-low ALU select switches: two-stage synchroniser, whole-bus
// debounce with a pending-candidate counter, hold-gated commit and a change strobe.
module alu_sel_debounce #(
  parameter int DEB_CYCLES = 240000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw_n,
  input  logic       hold,
  output logic [2:0] alusel,
  output logic       sel_chg,
  output logic       stable
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       PEND    = 1'b1;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       sync1_reg;
  logic [2:0]       sync2_reg;
  logic [0:0]       state_reg,  state_next;
  logic [2:0]       cand_reg,   cand_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [2:0]       alusel_reg, alusel_next;
  logic             chg_reg,    chg_next;
  logic             stable_reg, stable_next;

  // Per-bit synchroniser; stages reset to the "all switches off" level.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg[gi] <= 1'b1;
          sync2_reg[gi] <= 1'b1;
        end else begin
          sync1_reg[gi] <= sw_n[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    alusel_next = alusel_reg;
    chg_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sync2_reg != alusel_reg) begin
          cand_next  = sync2_reg;
          cnt_next   = CNT_ONE;
          state_next = PEND;
        end
      end
      PEND: begin
        // Return-to-committed and bounce-reload both take priority over a commit.
        if (sync2_reg == alusel_reg) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (sync2_reg != cand_reg) begin
          cand_next = sync2_reg;
          cnt_next  = CNT_ONE;
        end else if (cnt_reg == DEB_MAX) begin
          if (!hold) begin
            alusel_next = cand_reg;
            chg_next    = 1'b1;
            cnt_next    = '0;
            state_next  = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    stable_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cand_reg   <= 3'b111;
      cnt_reg    <= '0;
      alusel_reg <= 3'b111;
      chg_reg    <= 1'b0;
      stable_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cand_reg   <= cand_next;
      cnt_reg    <= cnt_next;
      alusel_reg <= alusel_next;
      chg_reg    <= chg_next;
      stable_reg <= stable_next;
    end
  end

  assign alusel  = alusel_reg;
  assign sel_chg = chg_reg;
  assign stable  = stable_reg;

endmodule

// File: tb/tb_alu_sel_debounce.sv
// Self-checking bench for alu_sel_debounce: directed scenarios plus randomized switch
// activity, compared every cycle against a run-length model of the debounce rules.
module tb_alu_sel_debounce;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [2:0] sw_n;
  logic       hold;
  logic [2:0] alusel;
  logic       sel_chg;
  logic       stable;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: synchroniser pipeline plus length of the current run of identical
  // synchronised values; a commit needs DEB+1 equal samples differing from alusel.
  logic [2:0] m_s1, m_s2, m_al, m_runv;
  int         m_runl;
  logic       m_chg, m_stable;

  alu_sel_debounce #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw_n(sw_n), .hold(hold),
    .alusel(alusel), .sel_chg(sel_chg), .stable(stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 3'b111; m_s2 = 3'b111; m_al = 3'b111; m_runv = 3'b111;
    m_runl = 0; m_chg = 1'b0; m_stable = 1'b1;
  endtask

  task automatic model_update();
    logic [2:0] pre_s2, pre_al;
    if (rst) begin
      model_reset();
      return;
    end
    pre_s2 = m_s2;
    pre_al = m_al;
    m_s2 = m_s1;
    m_s1 = sw_n;
    if (m_runl > 0 && pre_s2 == m_runv) begin
      if (m_runl < 1000) m_runl++;
    end else begin
      m_runv = pre_s2;
      m_runl = 1;
    end
    m_chg = (pre_s2 != pre_al) && (m_runl >= DEB + 1) && !hold;
    if (m_chg) m_al = pre_s2;
    m_stable = (pre_s2 == m_al);
  endtask

  task automatic compare();
    chk("alusel", int'(alusel), int'(m_al));
    chk("sel_chg", int'(sel_chg), int'(m_chg));
    chk("stable", int'(stable), int'(m_stable));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    model_update();
    compare();
    if (m_chg) $display("cycle %0d: commit alusel=%b", cycle, m_al);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_alusel", int'(alusel), 7);
    chk("rst_sel_chg", int'(sel_chg), 0);
    chk("rst_stable", int'(stable), 1);
    compare();
    #2;
    rst = 1'b0;
  endtask

  int first_chg;
  int nchg;

  initial begin
    rst = 1'b1; sw_n = 3'b111; hold = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    steps(3);

    // Reset while a debounce of 010 is in progress, then re-debounce from zero.
    $display("phase reset");
    sw_n = 3'b010;
    steps(3);
    mid_reset();
    steps(6);
    chk("reset_pre_commit", int'(alusel), 3'b111);
    step();
    chk("reset_commit_val", int'(alusel), 3'b010);
    chk("reset_commit_chg", int'(sel_chg), 1);
    step();
    chk("reset_chg_width", int'(sel_chg), 0);

    // Clean step 111 -> 110.
    $display("phase clean_step");
    sw_n = 3'b111;
    steps(10);
    sw_n = 3'b110;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("step_stable", int'(stable), (k >= 3 && k <= 6) ? 0 : 1);
      chk("step_alusel", int'(alusel), (k == 7) ? 3'b110 : 3'b111);
    end
    chk("step_chg", int'(sel_chg), 1);

    // Bounce between 100 and 111 every 2 cycles, then settle on 100.
    $display("phase bounce");
    nchg = 0;
    for (int i = 0; i < 10; i++) begin
      sw_n = ((i / 2) % 2 == 0) ? 3'b100 : 3'b111;
      step();
      if (sel_chg) nchg++;
    end
    chk("bounce_no_chg", nchg, 0);
    first_chg = 0;
    for (int k = 3; k <= 20 && first_chg == 0; k++) begin
      step();
      if (sel_chg) first_chg = k;
    end
    chk("bounce_latency", first_chg, 7);
    chk("bounce_val", int'(alusel), 3'b100);

    // Three-cycle glitch of 000 on a steady 011.
    $display("phase glitch");
    sw_n = 3'b011;
    steps(10);
    nchg = 0;
    sw_n = 3'b000;
    for (int i = 0; i < 3; i++) begin step(); if (sel_chg) nchg++; end
    sw_n = 3'b011;
    for (int i = 0; i < 10; i++) begin step(); if (sel_chg) nchg++; end
    chk("glitch_no_chg", nchg, 0);
    chk("glitch_val", int'(alusel), 3'b011);
    chk("glitch_stable", int'(stable), 1);

    // Hold defers the commit until released.
    $display("phase hold");
    sw_n = 3'b111;
    steps(10);
    hold = 1'b1;
    sw_n = 3'b001;
    steps(20);
    chk("hold_frozen", int'(alusel), 3'b111);
    hold = 1'b0;
    step();
    chk("hold_release_val", int'(alusel), 3'b001);
    chk("hold_release_chg", int'(sel_chg), 1);

    // Reset two cycles into a debounce of 000.
    $display("phase reset_pend");
    sw_n = 3'b111;
    steps(10);
    sw_n = 3'b000;
    steps(4);
    mid_reset();
    nchg = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sel_chg) nchg++;
      if (k == 7) chk("rpend_commit", int'(alusel), 3'b000);
    end
    chk("rpend_one_chg", nchg, 1);

    // Randomized switch activity with bursts of bouncing, hold and occasional resets.
    $display("phase random");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) sw_n = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 29) == 0) sw_n = sw_n ^ 3'($urandom_range(1, 7));
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      if ($urandom_range(0, 599) == 0) mid_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
